// File: rtl/e203_int_pkg.sv
// rtl/e203_int_pkg.sv - shared types and sizing helpers for the interrupt scheduler
package e203_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int pulse_cycles(input int clk_freq, input int pulse_us);
        return clk_freq * pulse_us;
    endfunction

    // Counter must reach the larger of the pulse length and the gap length.
    function automatic int cnt_width(input int pulse_cyc, input int gap_cycles);
        int m;
        m = (pulse_cyc > gap_cycles) ? pulse_cyc : gap_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/e203_rr_arbiter.sv
// rtl/e203_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module e203_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!any && req[(int'(ptr) + k) % NUM_SRC]) begin
                any = 1'b1;
                gnt[(int'(ptr) + k) % NUM_SRC] = 1'b1;
                idx = IDW'((int'(ptr) + k) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/e203_int_sched.sv
// rtl/e203_int_sched.sv - latches source events and emits one timed interrupt pulse per grant
module e203_int_sched
    import e203_int_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int CLK_FREQ   = 125,
    parameter int PULSE_US   = 1,
    parameter int GAP_CYCLES = 8,
    parameter int IDW        = $clog2(NUM_SRC)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               drop_clr,
    output logic               int_pulse,
    output logic [IDW-1:0]     int_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] drop_flag
);

    localparam int PULSE_CYC = pulse_cycles(CLK_FREQ, PULSE_US);
    localparam int CW        = cnt_width(PULSE_CYC, GAP_CYCLES);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [IDW-1:0]     ptr, ptr_n;
    logic               pulse_n, busy_n;
    logic [IDW-1:0]     id_n;
    logic [NUM_SRC-1:0] pending_n, drop_n;
    logic [NUM_SRC-1:0] grant_vec, new_req, drop_set;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;

    e203_rr_arbiter #(
        .NUM_SRC(NUM_SRC),
        .IDW    (IDW)
    ) u_arb (
        .req(pending & ~src_mask),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        pulse_n   = int_pulse;
        id_n      = int_id;
        busy_n    = busy;
        grant_vec = '0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_vec = arb_gnt;
                    pulse_n   = 1'b1;
                    id_n      = arb_idx;
                    busy_n    = 1'b1;
                    ptr_n     = (int'(arb_idx) == NUM_SRC - 1) ? '0 : arb_idx + IDW'(1);
                    cnt_n     = '0;
                    state_n   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (int'(cnt) == PULSE_CYC - 1) begin
                    pulse_n = 1'b0;
                    cnt_n   = '0;
                    if (GAP_CYCLES == 0) begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_GAP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (int'(cnt) >= GAP_CYCLES - 1) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                pulse_n = 1'b0;
                busy_n  = 1'b0;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // A fresh request on the edge its source is granted survives as a new event.
    always_comb begin
        new_req   = src_req & ~src_mask;
        drop_set  = new_req & pending & ~grant_vec;
        pending_n = (pending & ~grant_vec) | new_req;
        drop_n    = drop_clr ? drop_set : (drop_flag | drop_set);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            int_pulse <= 1'b0;
            int_id    <= '0;
            busy      <= 1'b0;
            pending   <= '0;
            drop_flag <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            int_pulse <= pulse_n;
            int_id    <= id_n;
            busy      <= busy_n;
            pending   <= pending_n;
            drop_flag <= drop_n;
        end
    end

endmodule
